// File: rtl/exe_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EXE stage.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up on completion.
module exe_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            kill,
   output logic            stall,
   output logic            out_valid,
   output logic [XLEN-1:0] result
);
   localparam int CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            op_q, op_d;
   logic                  sa_q, sa_d, sb_q, sb_d;
   logic [XLEN-1:0]       opnd_q, opnd_d;
   logic [2*XLEN-1:0]     acc_q, acc_d;
   logic [XLEN:0]         rem_q, rem_d;
   logic                  out_valid_q, out_valid_d;
   logic [XLEN-1:0]       result_q, result_d;

   logic                  sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
   logic [XLEN-1:0]       mag_a, mag_b;
   logic [XLEN:0]         mul_sum, div_shift, div_diff, rem_step;
   logic [2*XLEN-1:0]     acc_step, prod_fix;
   logic [XLEN-1:0]       quo_fix, rem_fix;

   assign sgn_a    = (funct3 == 3'd1) | (funct3 == 3'd2) | (funct3 == 3'd4) | (funct3 == 3'd6);
   assign sgn_b    = (funct3 == 3'd1) | (funct3 == 3'd4) | (funct3 == 3'd6);
   assign neg_a    = sgn_a & rs1_data[XLEN-1];
   assign neg_b    = sgn_b & rs2_data[XLEN-1];
   assign mag_a    = neg_a ? -rs1_data : rs1_data;
   assign mag_b    = neg_b ? -rs2_data : rs2_data;
   assign div_zero = funct3[2] & (rs2_data == '0);
   assign div_ovf  = funct3[2] & ~funct3[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_data);

   // acc_q holds product (upper) + multiplier (lower) for MUL*, and dividend/quotient (lower) for DIV*
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      if (op_q[2]) begin
         acc_step = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff[XLEN]};
         rem_step = div_diff[XLEN] ? div_shift : div_diff;
      end else begin
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
         rem_step = rem_q;
      end
      prod_fix = (sa_q ^ sb_q) ? -acc_step : acc_step;
      quo_fix  = (sa_q ^ sb_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      rem_fix  = sa_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      opnd_d      = opnd_q;
      acc_d       = acc_q;
      rem_d       = rem_q;
      out_valid_d = 1'b0;
      result_d    = result_q;
      case (state_q)
         IDLE: begin
            if (in_valid && !kill) begin
               op_d   = funct3;
               sa_d   = neg_a;
               sb_d   = neg_b;
               cnt_d  = '0;
               rem_d  = '0;
               opnd_d = funct3[2] ? mag_b : mag_a;
               acc_d  = {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
               if (div_zero) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  result_d    = funct3[1] ? rs1_data : '1;
               end else if (div_ovf) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  result_d    = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               acc_d = acc_step;
               rem_d = rem_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(XLEN-1)) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  case (op_q)
                     3'd0:             result_d = prod_fix[XLEN-1:0];
                     3'd1, 3'd2, 3'd3: result_d = prod_fix[2*XLEN-1:XLEN];
                     3'd4, 3'd5:       result_d = quo_fix;
                     default:          result_d = rem_fix;
                  endcase
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         opnd_q      <= '0;
         acc_q       <= '0;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         opnd_q      <= opnd_d;
         acc_q       <= acc_d;
         rem_q       <= rem_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

   // kill drops the stall in the same cycle so the flush is not held off
   assign stall     = rst & ~kill & (((state_q == IDLE) & in_valid) | (state_q == CALC));
   assign out_valid = out_valid_q;
   assign result    = result_q;
endmodule
